// File: rtl/memory_dp.sv
// Dual-port word memory with byte enables, a power-up INIT sweep that
// fills every word with INIT_VAL, same-address arbitration in favour of
// channel a, and a 1- or 2-cycle registered read pipeline per channel.

// Per-channel read/error response pipeline.
module memory_dp_rdpipe #(
   parameter int WIDTH  = 16,
   parameter int RD_LAT = 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             rd_fire,
   input  logic [WIDTH-1:0] rd_word,
   input  logic             acc_err,
   output logic             rvalid,
   output logic [WIDTH-1:0] rdata,
   output logic             err
);
   logic [RD_LAT:1]            vld_q;
   logic [RD_LAT:1][WIDTH-1:0] dat_q;
   logic [RD_LAT:0]            vld_pipe;
   logic [RD_LAT:0][WIDTH-1:0] dat_pipe;

   assign vld_pipe = {vld_q, rd_fire};
   assign dat_pipe = {dat_q, rd_word};

   // Shift read data down the pipe; a stage only loads when a read occupies
   // the stage feeding it, so the last stage holds its data between pulses.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         vld_q <= '0;
         dat_q <= '0;
         err   <= 1'b0;
      end else begin
         err <= acc_err;
         for (int s = 1; s <= RD_LAT; s++) begin
            vld_q[s] <= vld_pipe[s-1];
            if (vld_pipe[s-1]) dat_q[s] <= dat_pipe[s-1];
         end
      end
   end

   assign rvalid = vld_q[RD_LAT];
   assign rdata  = dat_q[RD_LAT];
endmodule

module memory_dp #(
   parameter int               WIDTH      = 16,
   parameter int               DEPTH      = 32,
   parameter int               ADDR_WIDTH = $clog2(DEPTH),
   parameter int               RD_LAT     = 1,
   parameter logic [WIDTH-1:0] INIT_VAL   = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  valid_a_i,
   input  logic                  wr_rd_en_a_i,
   input  logic [ADDR_WIDTH-1:0] addr_a_i,
   input  logic [WIDTH-1:0]      wdata_a_i,
   input  logic [WIDTH/8-1:0]    be_a_i,
   output logic                  ready_a_o,
   output logic [WIDTH-1:0]      rdata_a_o,
   output logic                  rvalid_a_o,
   output logic                  err_a_o,
   input  logic                  valid_b_i,
   input  logic                  wr_rd_en_b_i,
   input  logic [ADDR_WIDTH-1:0] addr_b_i,
   input  logic [WIDTH-1:0]      wdata_b_i,
   input  logic [WIDTH/8-1:0]    be_b_i,
   output logic                  ready_b_o,
   output logic [WIDTH-1:0]      rdata_b_o,
   output logic                  rvalid_b_o,
   output logic                  err_b_o,
   output logic                  init_done_o
);
   localparam int                    NB        = WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   init_cnt;
   logic [WIDTH-1:0]        mem [DEPTH];

   // Channel 0 = a, channel 1 = b.
   logic [1:0]                  valid, wr, ready, fire, inr, rvalid, err;
   logic [1:0][ADDR_WIDTH-1:0]  addr;
   logic [1:0][WIDTH-1:0]       wdata, rd_word, rdata;
   logic [1:0][NB-1:0]          be;
   logic                        run, conflict;

   assign valid = {valid_b_i, valid_a_i};
   assign wr    = {wr_rd_en_b_i, wr_rd_en_a_i};
   assign addr  = {addr_b_i, addr_a_i};
   assign wdata = {wdata_b_i, wdata_a_i};
   assign be    = {be_b_i, be_a_i};

   // Controller: sweep INIT_VAL into every word, then run forever.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= ST_INIT;
         init_cnt    <= '0;
         init_done_o <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               if (init_cnt == LAST_ADDR) begin
                  state       <= ST_RUN;
                  init_done_o <= 1'b1;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Same-address access with any write stalls b; two reads may share.
   assign run      = (state == ST_RUN);
   assign conflict = valid_a_i && valid_b_i && (addr_a_i == addr_b_i) &&
                     (wr_rd_en_a_i || wr_rd_en_b_i);
   assign ready    = {run && !conflict, run};
   assign fire     = valid & ready;
   assign ready_a_o = ready[0];
   assign ready_b_o = ready[1];

   // Address range check and read-word selection; out-of-range reads give 0.
   always_comb begin
      inr     = '0;
      rd_word = '0;
      for (int c = 0; c < 2; c++) begin
         inr[c] = (int'(addr[c]) < DEPTH);
         if (inr[c]) rd_word[c] = mem[addr[c]];
      end
   end

   // Storage: INIT sweep plus byte-masked writes. No reset so it maps to RAM;
   // arbitration guarantees the two write ports never share an address.
   always_ff @(posedge clk_i) begin
      if (state == ST_INIT) mem[init_cnt] <= INIT_VAL;
      for (int c = 0; c < 2; c++) begin
         if (fire[c] && wr[c] && inr[c]) begin
            for (int k = 0; k < NB; k++) begin
               if (be[c][k]) mem[addr[c]][8*k +: 8] <= wdata[c][8*k +: 8];
            end
         end
      end
   end

   for (genvar c = 0; c < 2; c++) begin : g_ch
      memory_dp_rdpipe #(
         .WIDTH  (WIDTH),
         .RD_LAT (RD_LAT)
      ) u_rdpipe (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .rd_fire (fire[c] && !wr[c]),
         .rd_word (rd_word[c]),
         .acc_err (fire[c] && !inr[c]),
         .rvalid  (rvalid[c]),
         .rdata   (rdata[c]),
         .err     (err[c])
      );
   end

   assign rvalid_a_o = rvalid[0];
   assign rvalid_b_o = rvalid[1];
   assign rdata_a_o  = rdata[0];
   assign rdata_b_o  = rdata[1];
   assign err_a_o    = err[0];
   assign err_b_o    = err[1];
endmodule
